axi_mem_rd_responder: RTL and testbench

AXI4 read-channel slave memory model. It answers the block-fill bursts that the instruction-side AXI master issues on behalf of imem.
- Accepts one AR request at a time.
- Returns len+1 data beats from an internal word array after a programmable latency.
- Supports INCR, FIXED and WRAP bursts.
- A backdoor load port lets benches and the SoC top preload program images.

---
 rtl/axi_mem_rd_responder.sv | 190 +++++++++++++++++++
 tb/tb_axi_mem_rd_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_rd_responder.sv
// AXI4 read-channel slave memory model: one outstanding AR, programmable latency,
// INCR/FIXED/WRAP bursts, per-beat SLVERR, and a backdoor preload port.
module axi_mem_rd_responder #(
  parameter int          MEM_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          READ_LATENCY = 2,
  parameter int          ID_WIDTH     = 4,
  parameter              INIT_FILE    = ""
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic                load_en,
  input  logic [31:0]         load_addr,
  input  logic [31:0]         load_data
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_BURST = 2'd2} state_t;

  function automatic logic addr_err(input logic [31:0] a);
    logic [32:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return diff[32] || ({2'b00, diff[31:2]} >= 32'(MEM_WORDS));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic wrap_len_ok(input logic [7:0] len);
    logic ok;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  // WRAP keeps the upper bits fixed and increments only inside the (len+1)*4 window
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [7:0] len);
    logic [31:0] mask;
    logic [31:0] na;
    mask = {22'd0, len, 2'b11};
    case (burst)
      2'b00:   na = a;
      2'b10:   na = (a & ~mask) | ((a + 32'd4) & mask);
      default: na = a + 32'd4;
    endcase
    return na;
  endfunction

  logic [31:0] mem_r [MEM_WORDS];

  state_t                state_r, state_s;
  logic                  arready_r, arready_s, rvalid_r, rvalid_s, rlast_r, rlast_s;
  logic [ID_WIDTH-1:0]   rid_r, rid_s, id_r, id_s;
  logic [31:0]           rdata_r, rdata_s, beat_addr_r, beat_addr_s, rd_word_s;
  logic [1:0]            rresp_r, rresp_s, burst_r, burst_s;
  logic [7:0]            len_r, len_s, beat_cnt_r, beat_cnt_s, lat_cnt_r, lat_cnt_s;
  logic                  cfg_err_r, cfg_err_s, beat_err_s;
  logic                  hs_s, load_s, done_s;

  assign hs_s   = (state_r == ST_IDLE) && arready_r && s_axi_arvalid;
  assign load_s = ((state_r == ST_WAIT) && (lat_cnt_r == 8'd0)) ||
                  ((state_r == ST_BURST) && (!rvalid_r || (s_axi_rready && !rlast_r)));
  assign done_s = (state_r == ST_BURST) && rvalid_r && s_axi_rready && rlast_r;

  assign rd_word_s  = mem_r[word_idx(beat_addr_r)];
  assign beat_err_s = cfg_err_r || addr_err(beat_addr_r);

  // state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_r <= ST_IDLE;
    else         state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = hs_s ? ((READ_LATENCY == 1) ? ST_BURST : ST_WAIT) : ST_IDLE;
      ST_WAIT:  state_s = (lat_cnt_r == 8'd0) ? ST_BURST : ST_WAIT;
      ST_BURST: state_s = done_s ? ST_IDLE : ST_BURST;
      default:  state_s = ST_IDLE;
    endcase
  end

  // next values of registered outputs and burst context
  always_comb begin
    arready_s   = (state_s == ST_IDLE);
    rvalid_s    = rvalid_r;
    rlast_s     = rlast_r;
    rid_s       = rid_r;
    rdata_s     = rdata_r;
    rresp_s     = rresp_r;
    id_s        = id_r;
    len_s       = len_r;
    burst_s     = burst_r;
    cfg_err_s   = cfg_err_r;
    lat_cnt_s   = lat_cnt_r;
    beat_addr_s = beat_addr_r;
    beat_cnt_s  = beat_cnt_r;
    if (hs_s) begin
      id_s        = s_axi_arid;
      len_s       = s_axi_arlen;
      burst_s     = s_axi_arburst;
      cfg_err_s   = (s_axi_arsize != 3'b010) || (s_axi_arburst == 2'b11) ||
                    ((s_axi_arburst == 2'b10) && !wrap_len_ok(s_axi_arlen));
      lat_cnt_s   = 8'(READ_LATENCY - 1);
      beat_addr_s = s_axi_araddr;
      beat_cnt_s  = 8'd0;
    end else if (load_s) begin
      rvalid_s    = 1'b1;
      rlast_s     = (beat_cnt_r == len_r);
      rid_s       = id_r;
      rresp_s     = beat_err_s ? 2'b10 : 2'b00;
      rdata_s     = beat_err_s ? 32'd0 : rd_word_s;
      beat_addr_s = next_addr(beat_addr_r, burst_r, len_r);
      beat_cnt_s  = beat_cnt_r + 8'd1;
    end else if (done_s) begin
      rvalid_s = 1'b0;
      rlast_s  = 1'b0;
    end else if (state_r == ST_WAIT) begin
      lat_cnt_s = lat_cnt_r - 8'd1;
    end else begin
      lat_cnt_s = lat_cnt_r;
    end
  end

  // output and context registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      arready_r   <= 1'b0;
      rvalid_r    <= 1'b0;
      rlast_r     <= 1'b0;
      rid_r       <= '0;
      rdata_r     <= 32'd0;
      rresp_r     <= 2'b00;
      id_r        <= '0;
      len_r       <= 8'd0;
      burst_r     <= 2'b00;
      cfg_err_r   <= 1'b0;
      lat_cnt_r   <= 8'd0;
      beat_addr_r <= 32'd0;
      beat_cnt_r  <= 8'd0;
    end else begin
      arready_r   <= arready_s;
      rvalid_r    <= rvalid_s;
      rlast_r     <= rlast_s;
      rid_r       <= rid_s;
      rdata_r     <= rdata_s;
      rresp_r     <= rresp_s;
      id_r        <= id_s;
      len_r       <= len_s;
      burst_r     <= burst_s;
      cfg_err_r   <= cfg_err_s;
      lat_cnt_r   <= lat_cnt_s;
      beat_addr_r <= beat_addr_s;
      beat_cnt_r  <= beat_cnt_s;
    end
  end

  // backdoor write; a beat fetched on the same edge still sees the old word
  always_ff @(posedge i_clk) begin
    if (load_en && !addr_err(load_addr)) mem_r[word_idx(load_addr)] <= load_data;
  end

  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rlast   = rlast_r;
  assign s_axi_rid     = rid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;

endmodule

// File: tb/tb_axi_mem_rd_responder.sv
// Scoreboard bench for axi_mem_rd_responder: expected beats are queued at issue time
// and a negedge monitor pops and compares every accepted R beat.
module tb_axi_mem_rd_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata, load_addr, load_data;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready, load_en;

  always #5 clk = ~clk;

  axi_mem_rd_responder dut (
    .i_clk(clk), .i_rstn(rstn),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    passed = 0;
  int    pops   = 0;
  int    rr_mode = 0;  // 0: rready=1, 1: 1,0,0,1,0,1 pattern, 2: driven by main thread

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                      input logic last);
    exp_q.push_back({id, data, resp, last});
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input bit chk_lat);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) check("ar_timeout", 64'd0, 64'd1);
    tick();
    arvalid = 1'b0;
    if (chk_lat) begin
      check("arready_after_hs", {63'd0, arready}, 64'd0);
      check("rvalid_lat_t0", {63'd0, rvalid}, 64'd0);
      tick();
      check("rvalid_lat_t1", {63'd0, rvalid}, 64'd0);
      tick();
      check("rvalid_lat_t2", {63'd0, rvalid}, 64'd1);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rvalid) && n < 300) begin tick(); n++; end
    check({name, "_done"}, {63'd0, (exp_q.size() == 0) && !rvalid}, 64'd1);
    check({name, "_arready"}, {63'd0, arready}, 64'd1);
  endtask

  // rready driver for the automatic modes
  initial begin
    logic [5:0] pat;
    int k;
    pat = 6'b101001;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode == 1) begin
        rready = pat[k];
        k = (k + 1) % 6;
      end else if (rr_mode == 0) begin
        rready = 1'b1;
      end
    end
  end

  // monitor: compares accepted beats and checks that stalled beats hold still
  beat_t cur, held;
  logic  stall_pend = 1'b0;
  always @(negedge clk) begin
    cur = {rid, rdata, rresp, rlast};
    if (!rstn) begin
      stall_pend = 1'b0;
    end else if (rvalid) begin
      if (stall_pend) check("stall_hold", 64'(cur), 64'(held));
      if (rready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(cur), 64'd0);
        else begin
          check("beat", 64'(cur), 64'(exp_q.pop_front()));
          pops++;
        end
        stall_pend = 1'b0;
      end else begin
        held = cur;
        stall_pend = 1'b1;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0;
    rstn = 1'b0; arvalid = 1'b0; arid = 4'd0; araddr = 32'd0; arlen = 8'd0;
    arsize = 3'b010; arburst = 2'b01; rready = 1'b1;
    load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
    repeat (3) tick();
    check("rst_arready", {63'd0, arready}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_rlast", {63'd0, rlast}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_rresp", {62'd0, rresp}, 64'd0);
    check("rst_rid", {60'd0, rid}, 64'd0);
    rstn = 1'b1;
    check("rel_arready_before_edge", {63'd0, arready}, 64'd0);
    tick();
    check("rel_arready_first_edge", {63'd0, arready}, 64'd1);

    for (int i = 0; i < 8; i++) load(32'(i * 4), 32'h1000_0000 + 32'(i));
    load(32'h0000_3FFC, 32'hCAFE_F00D);

    // back-to-back INCR
    for (int i = 0; i < 8; i++) push(4'h3, 32'h1000_0000 + 32'(i), 2'b00, i == 7);
    issue(4'h3, 32'h0, 8'd7, 3'b010, 2'b01, 1'b1);
    drain("incr");

    // backpressure
    rr_mode = 1;
    p0 = pops;
    for (int i = 0; i < 8; i++) push(4'h5, 32'h1000_0000 + 32'(i), 2'b00, i == 7);
    issue(4'h5, 32'h0, 8'd7, 3'b010, 2'b01, 1'b0);
    drain("bp");
    check("bp_beat_count", 64'(pops - p0), 64'd8);
    rr_mode = 0;

    // FIXED and WRAP
    for (int i = 0; i < 4; i++) push(4'h1, 32'h1000_0004, 2'b00, i == 3);
    issue(4'h1, 32'h10, 8'd3, 3'b010, 2'b00, 1'b0);
    drain("fixed");
    push(4'h2, 32'h1000_0006, 2'b00, 1'b0);
    push(4'h2, 32'h1000_0007, 2'b00, 1'b0);
    push(4'h2, 32'h1000_0004, 2'b00, 1'b0);
    push(4'h2, 32'h1000_0005, 2'b00, 1'b1);
    issue(4'h2, 32'h18, 8'd3, 3'b010, 2'b10, 1'b0);
    drain("wrap");

    // error cases: run off the end of memory, illegal size
    push(4'h6, 32'hCAFE_F00D, 2'b00, 1'b0);
    push(4'h6, 32'h0, 2'b10, 1'b1);
    issue(4'h6, 32'h3FFC, 8'd1, 3'b010, 2'b01, 1'b0);
    drain("oob");
    for (int i = 0; i < 3; i++) push(4'h7, 32'h0, 2'b10, i == 2);
    issue(4'h7, 32'h0, 8'd2, 3'b001, 2'b01, 1'b0);
    drain("badsize");

    // load racing a stalled beat
    rr_mode = 2;
    rready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'h8, 32'h1000_0000 + 32'(i), 2'b00, i == 3);
    issue(4'h8, 32'h0, 8'd3, 3'b010, 2'b01, 1'b0);
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    rready = 1'b1;
    tick();
    tick();
    rready = 1'b0;
    check("race_stalled_beat", {32'd0, rdata}, 64'h1000_0002);
    load(32'h8, 32'hDEAD_BEEF);
    tick();
    check("race_beat_unchanged", {32'd0, rdata}, 64'h1000_0002);
    rready = 1'b1;
    rr_mode = 0;
    drain("race");
    push(4'h9, 32'hDEAD_BEEF, 2'b00, 1'b1);
    issue(4'h9, 32'h8, 8'd0, 3'b010, 2'b01, 1'b0);
    drain("race_new");
    load(32'h8, 32'h1000_0002);

    // reset mid-burst
    p0 = pops;
    for (int i = 0; i < 8; i++) push(4'hA, 32'h1000_0000 + 32'(i), 2'b00, i == 7);
    issue(4'hA, 32'h0, 8'd7, 3'b010, 2'b01, 1'b0);
    n = 0;
    while ((pops - p0) < 2 && n < 50) begin tick(); n++; end
    rstn = 1'b0;
    #1;
    check("midrst_rvalid", {63'd0, rvalid}, 64'd0);
    check("midrst_rlast", {63'd0, rlast}, 64'd0);
    exp_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    check("midrst_arready_low", {63'd0, arready}, 64'd0);
    tick();
    check("midrst_arready_edge", {63'd0, arready}, 64'd1);
    for (int i = 0; i < 8; i++) push(4'hB, 32'h1000_0000 + 32'(i), 2'b00, i == 7);
    issue(4'hB, 32'h0, 8'd7, 3'b010, 2'b01, 1'b1);
    drain("after_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
